event_edge_monitor: RTL and testbench

- Synthesizable, multi-channel event monitor.
- Each channel synchronises an asynchronous input and detects a per-channel selectable event: any change, rising edge, falling edge, or level-high.
- Detected events latch as sticky pending flags with saturating occurrence counts.
- Pending events are presented one at a time over a valid/ready handshake, and an OR-aggregate flag is also provided.
- Sits between raw status/interrupt lines and a controller or interrupt sequencer.

---
 rtl/event_monitor_pkg.sv | 15 +
 rtl/event_channel.sv | 84 ++++++++
 rtl/event_edge_monitor.sv | 115 +++++++++++
 tb/tb_event_edge_monitor.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/event_monitor_pkg.sv
// Shared types and helpers for the event_edge_monitor slice.
package event_monitor_pkg;

  typedef enum logic [1:0] {
    MODE_ANY = 2'b00,
    MODE_POS = 2'b01,
    MODE_NEG = 2'b10,
    MODE_LVL = 2'b11
  } evt_mode_t;

  function automatic int unsigned ch_idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/event_channel.sv
// One monitored channel: synchroniser, previous sample, detector, sticky pending,
// saturating counter and (with EVT_TIMESTAMP_EN) first-occurrence timestamp.
module event_channel
  import event_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 8
`ifdef EVT_TIMESTAMP_EN
  ,
  parameter int unsigned TS_WIDTH    = 16
`endif
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 sig_in,
  input  logic                 enable,
  input  evt_mode_t            mode,
  input  logic                 warm_done,
  input  logic                 clear,
`ifdef EVT_TIMESTAMP_EN
  input  logic [TS_WIDTH-1:0]  ts_now,
  output logic [TS_WIDTH-1:0]  ts,
`endif
  output logic                 pending,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   prev;
  logic                   hit;
  logic                   det;

  assign s = sync[SYNC_STAGES-1];

  // prev tracks s even while disabled so re-enabling sees no stale edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      prev <= s;
    end
  end

  always_comb begin
    hit = 1'b0;
    unique case (mode)
      MODE_ANY: hit = s ^ prev;
      MODE_POS: hit = s & ~prev;
      MODE_NEG: hit = ~s & prev;
      MODE_LVL: hit = s;
    endcase
    det = hit & enable & warm_done;
  end

  // A detection coinciding with the consume restarts the channel instead of being lost
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
      cnt     <= '0;
    end else if (clear) begin
      pending <= det;
      cnt     <= det ? CNT_WIDTH'(1) : '0;
    end else if (det) begin
      pending <= 1'b1;
      if (!pending)
        cnt <= CNT_WIDTH'(1);
      else if (cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

`ifdef EVT_TIMESTAMP_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      ts <= '0;
    else if (det && (clear || !pending))
      ts <= ts_now;
  end
`endif

endmodule

// File: rtl/event_edge_monitor.sv
// Multi-channel event monitor: warm-up gate, fixed-priority presentation and
// valid/ready consume. Optional timestamps under `EVT_TIMESTAMP_EN.
module event_edge_monitor
  import event_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned TS_WIDTH    = 16
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NUM_CH-1:0]                 sig_in,
  input  logic [NUM_CH-1:0]                 ch_enable,
  input  logic [2*NUM_CH-1:0]               ch_mode,
  output logic                              evt_valid,
  input  logic                              evt_ready,
  output logic [ch_idx_width(NUM_CH)-1:0]   evt_ch,
  output logic [CNT_WIDTH-1:0]              evt_count,
`ifdef EVT_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]               evt_timestamp,
`endif
  output logic [NUM_CH-1:0]                 pending,
  output logic                              any_pending
);

  localparam int unsigned CH_W        = ch_idx_width(NUM_CH);
  localparam logic [2:0]  WARM_CYCLES = 3'(SYNC_STAGES + 1);

  if (NUM_CH < 1 || NUM_CH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
      CNT_WIDTH < 1 || TS_WIDTH < 1) begin : g_bad_params
    $error("event_edge_monitor: parameter out of range");
  end

  logic [2:0]           warm_cnt;
  logic                 warm_done;
  logic                 handshake;
  logic [NUM_CH-1:0]    clear;
  logic [CNT_WIDTH-1:0] cnt [NUM_CH];

  assign warm_done = (warm_cnt == WARM_CYCLES);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      warm_cnt <= '0;
    else if (!warm_done)
      warm_cnt <= warm_cnt + 3'd1;
  end

`ifdef EVT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_now;
  logic [TS_WIDTH-1:0] ts [NUM_CH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      ts_now <= '0;
    else
      ts_now <= ts_now + 1'b1;
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    event_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_WIDTH   (CNT_WIDTH)
`ifdef EVT_TIMESTAMP_EN
      ,
      .TS_WIDTH    (TS_WIDTH)
`endif
    ) u_channel (
      .clock     (clock),
      .reset_n   (reset_n),
      .sig_in    (sig_in[i]),
      .enable    (ch_enable[i]),
      .mode      (evt_mode_t'(ch_mode[2*i +: 2])),
      .warm_done (warm_done),
      .clear     (clear[i]),
`ifdef EVT_TIMESTAMP_EN
      .ts_now    (ts_now),
      .ts        (ts[i]),
`endif
      .pending   (pending[i]),
      .cnt       (cnt[i])
    );
  end

  assign any_pending = |pending;
  assign evt_valid   = any_pending;
  assign handshake   = evt_valid & evt_ready;

  // Descending scan so the lowest-index pending channel wins
  always_comb begin
    evt_ch    = '0;
    evt_count = '0;
`ifdef EVT_TIMESTAMP_EN
    evt_timestamp = '0;
`endif
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        evt_ch    = CH_W'(i);
        evt_count = cnt[i];
`ifdef EVT_TIMESTAMP_EN
        evt_timestamp = ts[i];
`endif
      end
    end
  end

  always_comb begin
    clear = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      clear[i] = handshake && (evt_ch == CH_W'(i));
  end

endmodule

// File: tb/tb_event_edge_monitor.sv
// Directed bench for event_edge_monitor (8 channels, 2 sync stages, 8-bit counts).
module tb_event_edge_monitor;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  sig_in;
  logic [7:0]  ch_enable;
  logic [15:0] ch_mode;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  evt_ch;
  logic [7:0]  evt_count;
  logic [7:0]  pending;
  logic        any_pending;
`ifdef EVT_TIMESTAMP_EN
  logic [15:0] evt_timestamp;
`endif

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clock = ~clock;

  event_edge_monitor #(
    .NUM_CH      (8),
    .SYNC_STAGES (2),
    .CNT_WIDTH   (8),
    .TS_WIDTH    (16)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .sig_in        (sig_in),
    .ch_enable     (ch_enable),
    .ch_mode       (ch_mode),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_ch        (evt_ch),
    .evt_count     (evt_count),
`ifdef EVT_TIMESTAMP_EN
    .evt_timestamp (evt_timestamp),
`endif
    .pending       (pending),
    .any_pending   (any_pending)
  );

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept();
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    sig_in    = 8'hFF;
    ch_enable = 8'hFF;
    ch_mode   = 16'h5555;
    evt_ready = 1'b0;
    tick(3);
    check("rst_valid",   {31'd0, evt_valid},   32'd0);
    check("rst_pending", {24'd0, pending},     32'd0);
    check("rst_any",     {31'd0, any_pending}, 32'd0);
    check("rst_ch",      {29'd0, evt_ch},      32'd0);
    check("rst_count",   {24'd0, evt_count},   32'd0);

    // Inputs high through reset must not look like edges after warm-up
    reset_n = 1'b1;
    tick(10);
    check("warm_pending", {24'd0, pending},   32'd0);
    check("warm_valid",   {31'd0, evt_valid}, 32'd0);

    // ch0 posedge latency: pending on the third edge after the change
    sig_in = 8'h00;
    tick(5);
    check("fall_ignored", {24'd0, pending}, 32'd0);
    sig_in = 8'h01;
    tick(2);
    check("lat_early", {24'd0, pending}, 32'd0);
    tick(1);
    check("lat_pending", {24'd0, pending},   32'h01);
    check("lat_valid",   {31'd0, evt_valid}, 32'd1);
    check("lat_ch",      {29'd0, evt_ch},    32'd0);
    check("lat_count",   {24'd0, evt_count}, 32'd1);
    accept();
    check("ack0_pending", {24'd0, pending},       32'd0);
    check("ack0_any",     {31'd0, any_pending},   32'd0);

    // ch3 negedge, ch5 any-change, priority and stacking counts
    ch_mode = 16'h5195;
    sig_in  = 8'h09;
    tick(5);
    check("mode_quiet", {24'd0, pending}, 32'd0);
    sig_in = 8'h21;
    tick(1);
    sig_in = 8'h01;
    tick(1);
    sig_in = 8'h21;
    tick(5);
    check("pri_pending", {24'd0, pending},   32'h28);
    check("pri_ch",      {29'd0, evt_ch},    32'd3);
    check("pri_count",   {24'd0, evt_count}, 32'd1);
    tick(3);
    check("hold_ch", {29'd0, evt_ch}, 32'd3);
    accept();
    check("next_ch",      {29'd0, evt_ch},    32'd5);
    check("next_count",   {24'd0, evt_count}, 32'd3);
    check("next_pending", {24'd0, pending},   32'h20);
    accept();
    check("drain_any",   {31'd0, any_pending}, 32'd0);
    check("drain_valid", {31'd0, evt_valid},   32'd0);

    // Disabled channel ignores its edge, and re-enable yields no stale edge
    ch_enable = 8'hBF;
    sig_in    = 8'h61;
    tick(5);
    check("dis_pending", {24'd0, pending}, 32'd0);
    ch_enable = 8'hFF;
    tick(5);
    check("reen_pending", {24'd0, pending}, 32'd0);

    // ch2 level-high saturates at 255
    ch_mode = 16'h51B5;
    tick(3);
    check("lvl_quiet", {24'd0, pending}, 32'd0);
    sig_in = 8'h65;
    tick(300);
    check("sat_pending", {24'd0, pending},   32'h04);
    check("sat_ch",      {29'd0, evt_ch},    32'd2);
    check("sat_count",   {24'd0, evt_count}, 32'hFF);
    sig_in = 8'h61;
    tick(5);
    check("sat_hold", {24'd0, evt_count}, 32'hFF);
    accept();
    check("sat_clear", {24'd0, pending}, 32'd0);

    // ch1 new posedge lands on the same edge as its consume
    sig_in = 8'h63;
    tick(3);
    check("co_first_pending", {24'd0, pending},   32'h02);
    check("co_first_count",   {24'd0, evt_count}, 32'd1);
    sig_in = 8'h61;
    tick(2);
    sig_in = 8'h63;
    tick(2);
    accept();
    check("co_pending", {24'd0, pending},   32'h02);
    check("co_count",   {24'd0, evt_count}, 32'd1);
    check("co_ch",      {29'd0, evt_ch},    32'd1);
    accept();
    check("co_drain", {31'd0, any_pending}, 32'd0);

    // Mid-run reset discards pending state without waiting for a clock
    sig_in = 8'h43;
    tick(4);
    check("pre_rst_pending", {24'd0, pending}, 32'h20);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_valid",   {31'd0, evt_valid},   32'd0);
    check("arst_pending", {24'd0, pending},     32'd0);
    check("arst_any",     {31'd0, any_pending}, 32'd0);
    check("arst_ch",      {29'd0, evt_ch},      32'd0);
    check("arst_count",   {24'd0, evt_count},   32'd0);

`ifdef EVT_TIMESTAMP_EN
    // Timer reads N after the Nth edge; detection at edge 65 captures 0x0040
    sig_in  = 8'h00;
    ch_mode = 16'h5555;
    tick(2);
    reset_n = 1'b1;
    tick(62);
    sig_in = 8'h10;
    tick(3);
    check("ts_pending", {24'd0, pending},      32'h10);
    check("ts_first",   {16'd0, evt_timestamp}, 32'h0040);
    sig_in = 8'h00;
    tick(13);
    sig_in = 8'h10;
    tick(3);
    check("ts_count", {24'd0, evt_count},     32'd2);
    check("ts_keep",  {16'd0, evt_timestamp}, 32'h0040);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
